int_float_conv: RTL and testbench

INT_FLOAT_CONV -- requirements
Module: int_float_conv

---
 rtl/int_float_conv_pkg.sv | 22 ++
 rtl/int_float_conv_lzc.sv | 23 ++
 rtl/int_float_conv.sv | 194 +++++++++++++++++++
 tb/tb_int_float_conv.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/int_float_conv_pkg.sv
// Shared definitions for the integer <-> float converter.
// Holds the mode encodings, default word/exponent widths and the helper
// functions that derive the mantissa width and exponent bias.
package int_float_conv_pkg;

    localparam logic MODE_ITOF = 1'b0;
    localparam logic MODE_FTOI = 1'b1;

    localparam int unsigned DEF_W     = 16;
    localparam int unsigned DEF_EXP_W = 8;

    // Mantissa bits left after the sign and exponent fields.
    function automatic int unsigned calc_man_w(input int unsigned w, input int unsigned exp_w);
        return w - 1 - exp_w;
    endfunction

    // IEEE-style exponent bias: 2^(exp_w-1) - 1.
    function automatic int unsigned calc_bias(input int unsigned exp_w);
        return (32'd1 << (exp_w - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/int_float_conv_lzc.sv
// Combinational leading-zero counter.
// Ports: d   - W-bit input word
//        cnt - number of leading zeros in d; W when d is all zeros
module int_float_conv_lzc #(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0]         d,
    output logic [$clog2(W):0]   cnt
);

    localparam int unsigned CW = $clog2(W) + 1;

    // Scan upward so the highest set bit is the last one to write cnt.
    always_comb begin
        cnt = CW'(W);
        for (int unsigned i = 0; i < W; i++) begin
            if (d[i]) begin
                cnt = CW'(W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/int_float_conv.sv
// Three-stage pipelined converter between two's-complement integers and a
// small sign/exponent/mantissa float format of the same width.
// Ports: clk, reset       - clock, synchronous active-high reset
//        in_valid/in_ready - input handshake; in_mode 0=itof, 1=ftoi
//        in_data          - integer or float word
//        out_valid/out_ready - output handshake
//        out_data         - converted word
//        out_inexact      - result differs from the input value
//        out_ovf          - ftoi result saturated
module int_float_conv
    import int_float_conv_pkg::*;
#(
    parameter int unsigned W     = DEF_W,
    parameter int unsigned EXP_W = DEF_EXP_W,
    parameter int unsigned RND   = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_mode,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_inexact,
    output logic         out_ovf
);

    localparam int unsigned MAN_W   = calc_man_w(W, EXP_W);
    localparam int unsigned BIAS    = calc_bias(EXP_W);
    localparam int unsigned SW      = $clog2(W) + 1;
    localparam int unsigned XW      = W + MAN_W;
    localparam int unsigned RW      = W - 1 - MAN_W;
    localparam int unsigned SAT_EXP = BIAS + W - 1;

    generate
        if (EXP_W < 2 || W < EXP_W + 2) begin : g_bad_params
            $error("int_float_conv: need EXP_W >= 2 and MAN_W >= 1");
        end
    endgenerate

    // Global pipeline advance: every stage moves together.
    logic adv_c;
    assign adv_c    = !out_valid || out_ready;
    assign in_ready = !reset && adv_c;

    // ---------------- S1: capture, sign/magnitude ----------------
    logic         s1_valid, s1_mode, s1_sign;
    logic [W-1:0] s1_word;
    logic [W-1:0] abs_c;

    // Most negative input wraps back to itself, which is 2^(W-1) unsigned.
    assign abs_c = in_data[W-1] ? (~in_data + W'(1)) : in_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
        end else if (adv_c) begin
            s1_valid <= in_valid;
            s1_mode  <= in_mode;
            s1_sign  <= in_data[W-1];
            s1_word  <= (in_mode == MODE_ITOF) ? abs_c : in_data;
        end
    end

    // ---------------- S2: leading-zero count, normalise ----------------
    logic [SW-1:0]    lz_c;
    logic [W-1:0]     norm_i_c;
    logic [SW-1:0]    exp_i_c;
    logic [EXP_W-1:0] f_exp_c;
    logic [MAN_W-1:0] f_man_c;
    logic [31:0]      f_exp32_c;
    logic             f_zero_c, f_big_c, f_min_c, f_sat_c;
    logic [SW-1:0]    f_sh_c;
    logic [XW-1:0]    f_ext_c;

    int_float_conv_lzc #(.W(W)) u_lzc (
        .d   (s1_word),
        .cnt (lz_c)
    );

    assign norm_i_c = s1_word << lz_c;
    assign exp_i_c  = SW'(W - 1) - lz_c;

    assign f_exp_c   = s1_word[W-2:MAN_W];
    assign f_man_c   = s1_word[MAN_W-1:0];
    assign f_exp32_c = 32'(f_exp_c);
    assign f_zero_c  = f_exp32_c < BIAS;
    assign f_big_c   = f_exp32_c >= SAT_EXP;
    // -2^(W-1) is representable, so it escapes saturation.
    assign f_min_c   = s1_sign && (f_exp32_c == SAT_EXP) && (f_man_c == '0);
    assign f_sat_c   = f_big_c && !f_min_c;
    // Clamp keeps the shift inside the extended word; clamped values are
    // either saturated or the exact minimum.
    assign f_sh_c    = f_big_c ? SW'(W - 1) : SW'(f_exp32_c - BIAS);
    assign f_ext_c   = XW'({1'b1, f_man_c}) << f_sh_c;

    logic         s2_valid, s2_mode, s2_sign, s2_zero, s2_inx, s2_sat;
    logic [W-1:0] s2_norm;
    logic [SW-1:0] s2_exp;
    logic         s2_zero_c, s2_inx_c, s2_sat_c;
    logic [W-1:0] s2_norm_c;

    always_comb begin : s2_mux
        s2_zero_c = (s1_word == '0);
        s2_inx_c  = 1'b0;
        s2_sat_c  = 1'b0;
        s2_norm_c = norm_i_c;
        if (s1_mode == MODE_FTOI) begin
            s2_zero_c = f_zero_c;
            s2_sat_c  = f_sat_c;
            s2_norm_c = f_ext_c[XW-1:MAN_W];
            if (f_zero_c) begin
                s2_inx_c = (f_exp_c != '0);
            end else begin
                s2_inx_c = f_sat_c || (f_ext_c[MAN_W-1:0] != '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid <= 1'b0;
        end else if (adv_c) begin
            s2_valid <= s1_valid;
            s2_mode  <= s1_mode;
            s2_sign  <= s1_sign;
            s2_zero  <= s2_zero_c;
            s2_inx   <= s2_inx_c;
            s2_sat   <= s2_sat_c;
            s2_norm  <= s2_norm_c;
            s2_exp   <= exp_i_c;
        end
    end

    // ---------------- S3: round, pack, flags ----------------
    logic [MAN_W-1:0] i_man_c;
    logic             i_guard_c, i_sticky_c, i_up_c;
    logic [MAN_W:0]   i_man_r_c;
    logic [EXP_W-1:0] i_exp_c;
    logic [W-1:0]     i_res_c, f_res_c, res_c;
    logic             inx_c, ovf_c;

    // Leading one sits at bit W-1 and is implicit in the packed format.
    assign i_man_c    = s2_norm[W-2 -: MAN_W];
    assign i_guard_c  = s2_norm[RW-1];
    assign i_sticky_c = |s2_norm[RW-2:0];
    assign i_up_c     = (RND != 0) && i_guard_c && (i_sticky_c || i_man_c[0]);
    assign i_man_r_c  = {1'b0, i_man_c} + (MAN_W + 1)'(i_up_c);
    // Mantissa carry-out leaves zeros in the low bits and bumps the exponent.
    assign i_exp_c    = EXP_W'(BIAS + 32'(s2_exp) + 32'(i_man_r_c[MAN_W]));
    assign i_res_c    = {s2_sign, i_exp_c, i_man_r_c[MAN_W-1:0]};

    always_comb begin : f_pack
        f_res_c = s2_sign ? (~s2_norm + W'(1)) : s2_norm;
        if (s2_sat) begin
            f_res_c = s2_sign ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end

    always_comb begin : s3_mux
        res_c = '0;
        inx_c = 1'b0;
        ovf_c = 1'b0;
        if (s2_mode == MODE_FTOI) begin
            inx_c = s2_inx;
            ovf_c = s2_sat;
            if (!s2_zero) begin
                res_c = f_res_c;
            end
        end else if (!s2_zero) begin
            res_c = i_res_c;
            inx_c = i_guard_c || i_sticky_c;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_inexact <= 1'b0;
            out_ovf     <= 1'b0;
        end else if (adv_c) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                out_data    <= res_c;
                out_inexact <= inx_c;
                out_ovf     <= ovf_c;
            end
        end
    end

endmodule

// File: tb/tb_int_float_conv.sv
// Directed self-checking bench for int_float_conv (default widths).
// A second instance with truncation (RND=0) runs in lockstep on the same inputs.
module tb_int_float_conv;
    import int_float_conv_pkg::*;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_mode, out_ready;
    logic [15:0] in_data;
    logic        in_ready, out_valid, out_inexact, out_ovf;
    logic [15:0] out_data;
    logic        t_in_ready, t_out_valid, t_out_inexact, t_out_ovf;
    logic [15:0] t_out_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    int_float_conv #(.W(16), .EXP_W(8), .RND(1)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_inexact(out_inexact), .out_ovf(out_ovf)
    );

    int_float_conv #(.W(16), .EXP_W(8), .RND(0)) dut_t (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(t_in_ready), .in_mode(in_mode), .in_data(in_data),
        .out_valid(t_out_valid), .out_ready(out_ready), .out_data(t_out_data),
        .out_inexact(t_out_inexact), .out_ovf(t_out_ovf)
    );

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_mode = MODE_ITOF; in_data = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (in_ready !== 1'b0)   begin bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        total++; if (t_in_ready !== 1'b0) begin bad++; $display("FAIL reset_t_in_ready: got %b want 0", t_in_ready); end
        total++; if (out_valid !== 1'b0)  begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++; if (out_data !== 16'h0)  begin bad++; $display("FAIL reset_out_data: got %h want 0000", out_data); end
        total++; if (out_inexact !== 1'b0) begin bad++; $display("FAIL reset_inexact: got %b want 0", out_inexact); end
        total++; if (out_ovf !== 1'b0)    begin bad++; $display("FAIL reset_ovf: got %b want 0", out_ovf); end
        reset = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1)   begin bad++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_itof();
        logic [15:0] vin   [7] = '{16'h0001, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0000, 16'h0181, 16'h0183};
        logic [15:0] exp_r [7] = '{16'h3F80, 16'hBF80, 16'h4700, 16'hC700, 16'h0000, 16'h43C0, 16'h43C2};
        logic [15:0] exp_t [7] = '{16'h3F80, 16'hBF80, 16'h46FF, 16'hC700, 16'h0000, 16'h43C0, 16'h43C1};
        logic        exp_x [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        int n;
        for (int i = 0; i < 7; i++) begin
            in_mode = MODE_ITOF; in_data = vin[i]; in_valid = 1'b1; out_ready = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            n = 1;
            while (!out_valid && n < 10) begin @(posedge clk); #1; n++; end
            total++; if (n !== 3) begin bad++; $display("FAIL itof_latency[%0d]: got %0d want 3", i, n); end
            total++; if (out_data !== exp_r[i]) begin bad++; $display("FAIL itof_data[%0d]: got %h want %h", i, out_data, exp_r[i]); end
            total++; if (out_inexact !== exp_x[i]) begin bad++; $display("FAIL itof_inexact[%0d]: got %b want %b", i, out_inexact, exp_x[i]); end
            total++; if (out_ovf !== 1'b0) begin bad++; $display("FAIL itof_ovf[%0d]: got %b want 0", i, out_ovf); end
            total++; if (t_out_valid !== 1'b1) begin bad++; $display("FAIL itof_trunc_valid[%0d]: got %b want 1", i, t_out_valid); end
            total++; if (t_out_data !== exp_t[i]) begin bad++; $display("FAIL itof_trunc_data[%0d]: got %h want %h", i, t_out_data, exp_t[i]); end
            total++; if (t_out_inexact !== exp_x[i]) begin bad++; $display("FAIL itof_trunc_inexact[%0d]: got %b want %b", i, t_out_inexact, exp_x[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_ftoi();
        logic [15:0] vin   [11] = '{16'h4049, 16'h4780, 16'hC700, 16'h3F00, 16'h0000, 16'hC049,
                                    16'h4040, 16'hC780, 16'hC701, 16'h46FF, 16'h3F80};
        logic [15:0] exp_d [11] = '{16'h0003, 16'h7FFF, 16'h8000, 16'h0000, 16'h0000, 16'hFFFD,
                                    16'h0003, 16'h8000, 16'h8000, 16'h7F80, 16'h0001};
        logic        exp_x [11] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic        exp_o [11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        int n;
        for (int i = 0; i < 11; i++) begin
            in_mode = MODE_FTOI; in_data = vin[i]; in_valid = 1'b1; out_ready = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            n = 1;
            while (!out_valid && n < 10) begin @(posedge clk); #1; n++; end
            total++; if (n !== 3) begin bad++; $display("FAIL ftoi_latency[%0d]: got %0d want 3", i, n); end
            total++; if (out_data !== exp_d[i]) begin bad++; $display("FAIL ftoi_data[%0d]: got %h want %h", i, out_data, exp_d[i]); end
            total++; if (out_inexact !== exp_x[i]) begin bad++; $display("FAIL ftoi_inexact[%0d]: got %b want %b", i, out_inexact, exp_x[i]); end
            total++; if (out_ovf !== exp_o[i]) begin bad++; $display("FAIL ftoi_ovf[%0d]: got %b want %b", i, out_ovf, exp_o[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        logic        wmode [4] = '{MODE_ITOF, MODE_FTOI, MODE_ITOF, MODE_FTOI};
        logic [15:0] wdata [4] = '{16'h0001, 16'h4049, 16'hFFFF, 16'hC700};
        logic [15:0] wexp  [4] = '{16'h3F80, 16'h0003, 16'hBF80, 16'h8000};
        logic        wx    [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        int got;
        logic acc;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_mode = wmode[i]; in_data = wdata[i]; in_valid = 1'b1;
            #1;
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_accept[%0d]: got %b want 1", i, in_ready); end
            @(posedge clk); #1;
        end
        in_mode = wmode[3]; in_data = wdata[3]; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_valid[%0d]: got %b want 1", k, out_valid); end
            total++; if (out_data !== wexp[0]) begin bad++; $display("FAIL stall_data[%0d]: got %h want %h", k, out_data, wexp[0]); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready[%0d]: got %b want 0", k, in_ready); end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 20 && got < 4; c++) begin
            acc = in_valid && in_ready;
            if (out_valid && out_ready) begin
                total++; if (out_data !== wexp[got]) begin bad++; $display("FAIL b2b_data[%0d]: got %h want %h", got, out_data, wexp[got]); end
                total++; if (out_inexact !== wx[got]) begin bad++; $display("FAIL b2b_inexact[%0d]: got %b want %b", got, out_inexact, wx[got]); end
                got++;
            end
            @(posedge clk); #1;
            if (acc) in_valid = 1'b0;
        end
        total++; if (got !== 4) begin bad++; $display("FAIL b2b_count: got %0d want 4", got); end
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midflight();
        int n;
        logic seen;
        out_ready = 1'b1;
        in_mode = MODE_ITOF; in_data = 16'h0001; in_valid = 1'b1;
        @(posedge clk); #1;
        in_mode = MODE_FTOI; in_data = 16'h4780;
        @(posedge clk); #1;
        in_valid = 1'b0; reset = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_reset_in_ready: got %b want 0", in_ready); end
        @(posedge clk); #1;
        reset = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_valid: got %b want 0", out_valid); end
        total++; if (out_data !== 16'h0) begin bad++; $display("FAIL mid_reset_data: got %h want 0000", out_data); end
        total++; if (out_ovf !== 1'b0) begin bad++; $display("FAIL mid_reset_ovf: got %b want 0", out_ovf); end
        total++; if (out_inexact !== 1'b0) begin bad++; $display("FAIL mid_reset_inexact: got %b want 0", out_inexact); end
        seen = 1'b0;
        repeat (5) begin
            if (out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL mid_reset_ghost: got %b want 0", seen); end
        in_mode = MODE_ITOF; in_data = 16'h0003; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 10) begin @(posedge clk); #1; n++; end
        total++; if (n !== 3) begin bad++; $display("FAIL post_reset_latency: got %0d want 3", n); end
        total++; if (out_data !== 16'h4040) begin bad++; $display("FAIL post_reset_data: got %h want 4040", out_data); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_itof();
        test_ftoi();
        test_back_to_back();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
